rob_param: RTL and testbench

- Parametrised reorder buffer, successor to the single-commit ROB in the o3cpu core.
- Allocates entries in program order from decode and accepts results from NUM_WB writeback (CDB) ports.
- Forwards operand values to decode and retires up to COMMIT_W in-order instructions per cycle to the register file, LSQ and branch unit.
- Self-flushes on a committed misprediction.

---
 rtl/rob_param.sv | 204 ++++++++++++++++++++
 tb/tb_rob_param.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, multi-port writeback, operand forwarding,
// up to COMMIT_W in-order retirements per cycle and self-flush on a committed mispredict.
module rob_param #(
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned IDX_W    = 4,
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NUM_WB   = 3,
    parameter int unsigned COMMIT_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      alloc_valid,
    output logic                      alloc_ready,
    input  logic [1:0]                alloc_kind,
    input  logic [XLEN-1:0]           alloc_pc,
    input  logic [4:0]                alloc_rd,
    input  logic                      alloc_pred_taken,
    output logic [IDX_W-1:0]          alloc_tag,
    input  logic [IDX_W-1:0]          rd_tag1,
    input  logic [IDX_W-1:0]          rd_tag2,
    output logic                      rd_ready1,
    output logic                      rd_ready2,
    output logic [XLEN-1:0]           rd_data1,
    output logic [XLEN-1:0]           rd_data2,
    input  logic [NUM_WB-1:0]         wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]   wb_tag,
    input  logic [NUM_WB*XLEN-1:0]    wb_data,
    input  logic [NUM_WB-1:0]         wb_taken,
    input  logic [NUM_WB*XLEN-1:0]    wb_target,
    output logic [COMMIT_W-1:0]       cm_valid,
    output logic [COMMIT_W-1:0]       cm_regwe,
    output logic [COMMIT_W-1:0]       cm_store,
    output logic [COMMIT_W*5-1:0]     cm_rd,
    output logic [COMMIT_W*XLEN-1:0]  cm_data,
    output logic [COMMIT_W*IDX_W-1:0] cm_tag,
    output logic                      br_valid,
    output logic [XLEN-1:0]           br_pc,
    output logic [XLEN-1:0]           br_target,
    output logic                      br_taken,
    output logic                      br_mispredict,
    output logic [IDX_W:0]            count,
    output logic                      empty,
    output logic                      full
);

    localparam int unsigned PTR_W = IDX_W + 1;
    localparam logic [1:0] KindAlu   = 2'd0;
    localparam logic [1:0] KindStore = 2'd1;
    localparam logic [1:0] KindJalr  = 2'd3;

    logic [DEPTH-1:0] ent_valid, ent_ready, ent_pred, ent_act;
    logic [XLEN-1:0]  ent_data   [DEPTH];
    logic [XLEN-1:0]  ent_pc     [DEPTH];
    logic [XLEN-1:0]  ent_target [DEPTH];
    logic [1:0]       ent_kind   [DEPTH];
    logic [4:0]       ent_rd     [DEPTH];
    logic [PTR_W-1:0] head, tail;

    assign count       = tail - head;
    assign empty       = (count == '0);
    assign full        = (count == PTR_W'(DEPTH));
    assign alloc_ready = !full;
    assign alloc_tag   = tail[IDX_W-1:0];

    // Registered entry valid/ready first, then in-flight writebacks (highest port wins).
    function automatic logic [XLEN:0] lookup(input logic [IDX_W-1:0] t);
        logic [XLEN:0] r;
        r = '0;
        if (ent_valid[t] && ent_ready[t]) begin
            r = {1'b1, ent_data[t]};
        end else begin
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && (wb_tag[p*IDX_W +: IDX_W] == t)) begin
                    r = {1'b1, wb_data[p*XLEN +: XLEN]};
                end
            end
        end
        return r;
    endfunction

    assign {rd_ready1, rd_data1} = lookup(rd_tag1);
    assign {rd_ready2, rd_data2} = lookup(rd_tag2);

    logic [COMMIT_W-1:0]       cm_valid_d, cm_regwe_d, cm_store_d;
    logic [COMMIT_W*5-1:0]     cm_rd_d;
    logic [COMMIT_W*XLEN-1:0]  cm_data_d;
    logic [COMMIT_W*IDX_W-1:0] cm_tag_d;
    logic                      br_valid_d, br_taken_d, br_mis_d;
    logic [XLEN-1:0]           br_pc_d, br_target_d;
    logic [PTR_W-1:0]          n_ret;
    logic [IDX_W-1:0]          idx;
    logic                      stop;

    // Retirement scan stops at the first unready entry or just after a branch.
    always_comb begin
        cm_valid_d  = '0;
        cm_regwe_d  = '0;
        cm_store_d  = '0;
        cm_rd_d     = '0;
        cm_data_d   = '0;
        cm_tag_d    = '0;
        br_valid_d  = 1'b0;
        br_taken_d  = 1'b0;
        br_mis_d    = 1'b0;
        br_pc_d     = '0;
        br_target_d = '0;
        n_ret       = '0;
        idx         = '0;
        stop        = 1'b0;
        for (int i = 0; i < COMMIT_W; i++) begin
            idx = head[IDX_W-1:0] + IDX_W'(i);
            if (!stop && (PTR_W'(i) < count) && ent_valid[idx] && ent_ready[idx]) begin
                cm_valid_d[i]               = 1'b1;
                cm_regwe_d[i]               = (ent_kind[idx] == KindAlu) ||
                                              (ent_kind[idx] == KindJalr);
                cm_store_d[i]               = (ent_kind[idx] == KindStore);
                cm_rd_d[i*5 +: 5]           = ent_rd[idx];
                cm_data_d[i*XLEN +: XLEN]   = ent_data[idx];
                cm_tag_d[i*IDX_W +: IDX_W]  = idx;
                n_ret                       = n_ret + PTR_W'(1);
                if (ent_kind[idx][1]) begin
                    br_valid_d  = 1'b1;
                    br_pc_d     = ent_pc[idx];
                    br_target_d = ent_target[idx];
                    br_taken_d  = ent_act[idx];
                    br_mis_d    = (ent_kind[idx] == KindJalr) || (ent_pred[idx] != ent_act[idx]);
                    stop        = 1'b1;
                end
            end else begin
                stop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ent_valid     <= '0;
            ent_ready     <= '0;
            head          <= '0;
            tail          <= '0;
            cm_valid      <= '0;
            cm_regwe      <= '0;
            cm_store      <= '0;
            cm_rd         <= '0;
            cm_data       <= '0;
            cm_tag        <= '0;
            br_valid      <= 1'b0;
            br_pc         <= '0;
            br_target     <= '0;
            br_taken      <= 1'b0;
            br_mispredict <= 1'b0;
        end else begin
            cm_valid      <= cm_valid_d;
            cm_regwe      <= cm_regwe_d;
            cm_store      <= cm_store_d;
            cm_rd         <= cm_rd_d;
            cm_data       <= cm_data_d;
            cm_tag        <= cm_tag_d;
            br_valid      <= br_valid_d;
            br_pc         <= br_pc_d;
            br_target     <= br_target_d;
            br_taken      <= br_taken_d;
            br_mispredict <= br_mis_d;

            for (int i = 0; i < COMMIT_W; i++) begin
                if (cm_valid_d[i]) begin
                    ent_valid[head[IDX_W-1:0] + IDX_W'(i)] <= 1'b0;
                end
            end

            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid[p] && ent_valid[wb_tag[p*IDX_W +: IDX_W]]) begin
                    ent_ready[wb_tag[p*IDX_W +: IDX_W]]  <= 1'b1;
                    ent_data[wb_tag[p*IDX_W +: IDX_W]]   <= wb_data[p*XLEN +: XLEN];
                    ent_act[wb_tag[p*IDX_W +: IDX_W]]    <= wb_taken[p];
                    ent_target[wb_tag[p*IDX_W +: IDX_W]] <= wb_target[p*XLEN +: XLEN];
                end
            end

            if (alloc_valid && alloc_ready) begin
                ent_valid[tail[IDX_W-1:0]] <= 1'b1;
                ent_ready[tail[IDX_W-1:0]] <= (alloc_kind == KindStore);
                ent_data[tail[IDX_W-1:0]]  <= '0;
                ent_kind[tail[IDX_W-1:0]]  <= alloc_kind;
                ent_pc[tail[IDX_W-1:0]]    <= alloc_pc;
                ent_rd[tail[IDX_W-1:0]]    <= alloc_rd;
                ent_pred[tail[IDX_W-1:0]]  <= alloc_pred_taken;
                tail                       <= tail + PTR_W'(1);
            end

            head <= head + n_ret;

            // Committed mispredict squashes everything younger, including this cycle's alloc.
            if (br_mis_d) begin
                ent_valid <= '0;
                ent_ready <= '0;
                head      <= '0;
                tail      <= '0;
            end
        end
    end

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: directed stimulus pushes expected retirements,
// a negedge monitor pops and compares whenever the ROB presents a commit.
module tb_rob_param;

    localparam int unsigned DEPTH    = 16;
    localparam int unsigned IDX_W    = 4;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_WB   = 3;
    localparam int unsigned COMMIT_W = 2;

    logic                      clk, rst, flush, alloc_valid, alloc_ready, alloc_pred_taken;
    logic [1:0]                alloc_kind;
    logic [XLEN-1:0]           alloc_pc;
    logic [4:0]                alloc_rd;
    logic [IDX_W-1:0]          alloc_tag, rd_tag1, rd_tag2;
    logic                      rd_ready1, rd_ready2;
    logic [XLEN-1:0]           rd_data1, rd_data2;
    logic [NUM_WB-1:0]         wb_valid, wb_taken;
    logic [NUM_WB*IDX_W-1:0]   wb_tag;
    logic [NUM_WB*XLEN-1:0]    wb_data, wb_target;
    logic [COMMIT_W-1:0]       cm_valid, cm_regwe, cm_store;
    logic [COMMIT_W*5-1:0]     cm_rd;
    logic [COMMIT_W*XLEN-1:0]  cm_data;
    logic [COMMIT_W*IDX_W-1:0] cm_tag;
    logic                      br_valid, br_taken, br_mispredict;
    logic [XLEN-1:0]           br_pc, br_target;
    logic [IDX_W:0]            count;
    logic                      empty, full;

    rob_param #(
        .DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN), .NUM_WB(NUM_WB), .COMMIT_W(COMMIT_W)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_kind(alloc_kind),
        .alloc_pc(alloc_pc), .alloc_rd(alloc_rd), .alloc_pred_taken(alloc_pred_taken),
        .alloc_tag(alloc_tag),
        .rd_tag1(rd_tag1), .rd_tag2(rd_tag2), .rd_ready1(rd_ready1), .rd_ready2(rd_ready2),
        .rd_data1(rd_data1), .rd_data2(rd_data2),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_taken(wb_taken),
        .wb_target(wb_target),
        .cm_valid(cm_valid), .cm_regwe(cm_regwe), .cm_store(cm_store), .cm_rd(cm_rd),
        .cm_data(cm_data), .cm_tag(cm_tag),
        .br_valid(br_valid), .br_pc(br_pc), .br_target(br_target), .br_taken(br_taken),
        .br_mispredict(br_mispredict),
        .count(count), .empty(empty), .full(full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  valid, regwe, store;
        logic [9:0]  rd;
        logic [63:0] data;
        logic [7:0]  tag;
        logic        bv, bt, bm;
        logic [31:0] bpc, btgt;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] v, input logic [1:0] we, input logic [1:0] st,
                            input logic [9:0] rd, input logic [63:0] data, input logic [7:0] tag,
                            input logic bv, input logic bt, input logic bm,
                            input logic [31:0] bpc, input logic [31:0] btgt);
        exp_t e;
        e.valid = v; e.regwe = we; e.store = st; e.rd = rd; e.data = data; e.tag = tag;
        e.bv = bv; e.bt = bt; e.bm = bm; e.bpc = bpc; e.btgt = btgt;
        q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst && (cm_valid != 2'b00 || br_valid)) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_commit: cm_valid=%b br_valid=%b, expected none",
                         cm_valid, br_valid);
            end else begin
                mon_e = q.pop_front();
                check("cm_valid", 64'(cm_valid), 64'(mon_e.valid));
                check("cm_regwe", 64'(cm_regwe), 64'(mon_e.regwe));
                check("cm_store", 64'(cm_store), 64'(mon_e.store));
                check("cm_rd", 64'(cm_rd), 64'(mon_e.rd));
                check("cm_data", cm_data, mon_e.data);
                check("cm_tag", 64'(cm_tag), 64'(mon_e.tag));
                check("br_valid", 64'(br_valid), 64'(mon_e.bv));
                check("br_taken", 64'(br_taken), 64'(mon_e.bt));
                check("br_mispredict", 64'(br_mispredict), 64'(mon_e.bm));
                check("br_pc", 64'(br_pc), 64'(mon_e.bpc));
                check("br_target", 64'(br_target), 64'(mon_e.btgt));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_wb;
        wb_valid = '0; wb_tag = '0; wb_data = '0; wb_taken = '0; wb_target = '0;
    endtask

    task automatic wb(input int p, input logic [3:0] tag, input logic [31:0] data,
                      input logic taken, input logic [31:0] target);
        wb_valid[p]          = 1'b1;
        wb_tag[p*4 +: 4]     = tag;
        wb_data[p*32 +: 32]  = data;
        wb_taken[p]          = taken;
        wb_target[p*32 +: 32] = target;
    endtask

    task automatic alloc(input logic [1:0] k, input logic [4:0] rd, input logic [31:0] pc,
                         input logic pred, input int exp_tag);
        alloc_valid = 1'b1; alloc_kind = k; alloc_rd = rd; alloc_pc = pc;
        alloc_pred_taken = pred;
        #1;
        check("alloc_tag", 64'(alloc_tag), 64'(exp_tag));
        tick;
        alloc_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; alloc_kind = '0; alloc_pc = '0;
        alloc_rd = '0; alloc_pred_taken = 1'b0; rd_tag1 = '0; rd_tag2 = '0;
        clear_wb;
        tick; tick;
        rst = 1'b0;
        check("reset_count", 64'(count), 64'd0);
        check("reset_empty", 64'(empty), 64'd1);
        check("reset_cm_valid", 64'(cm_valid), 64'd0);
        check("reset_br_valid", 64'(br_valid), 64'd0);

        // Fill all 16 entries; the 17th request must bounce.
        for (int i = 0; i < 16; i++) alloc(2'd0, 5'(i), 32'(i * 4), 1'b0, i);
        check("full_after_16", 64'(full), 64'd1);
        check("alloc_ready_full", 64'(alloc_ready), 64'd0);
        check("count_16", 64'(count), 64'd16);
        alloc_valid = 1'b1;
        tick;
        alloc_valid = 1'b0;
        check("count_stays_16", 64'(count), 64'd16);
        flush = 1'b1; tick; flush = 1'b0;
        check("flush_count", 64'(count), 64'd0);

        // Dual retirement, writebacks on ports 0 and 2.
        alloc(2'd0, 5'd5, 32'h10, 1'b0, 0);
        alloc(2'd0, 5'd6, 32'h14, 1'b0, 1);
        push_exp(2'b11, 2'b11, 2'b00, {5'd6, 5'd5}, {32'hB, 32'hA}, {4'd1, 4'd0},
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        wb(0, 4'd0, 32'hA, 1'b0, 32'h0);
        wb(2, 4'd1, 32'hB, 1'b0, 32'h0);
        tick; clear_wb;
        tick;
        check("empty_after_dual", 64'(empty), 64'd1);

        // Store is ready at alloc and retires alone; ALU op follows.
        push_exp(2'b01, 2'b00, 2'b01, 10'd0, 64'd0, {4'd0, 4'd2},
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        push_exp(2'b01, 2'b01, 2'b00, {5'd0, 5'd7}, 64'h77, {4'd0, 4'd3},
                 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        alloc(2'd1, 5'd0, 32'h20, 1'b0, 2);
        alloc(2'd0, 5'd7, 32'h24, 1'b0, 3);
        wb(1, 4'd3, 32'h77, 1'b0, 32'h0);
        tick; clear_wb;
        tick;
        check("empty_after_store", 64'(empty), 64'd1);

        // Mispredicted branch squashes three ready younger ops.
        alloc(2'd2, 5'd0, 32'h40, 1'b0, 4);
        alloc(2'd0, 5'd1, 32'h44, 1'b0, 5);
        alloc(2'd0, 5'd2, 32'h48, 1'b0, 6);
        alloc(2'd0, 5'd3, 32'h4C, 1'b0, 7);
        wb(0, 4'd5, 32'h1, 1'b0, 32'h0);
        wb(1, 4'd6, 32'h2, 1'b0, 32'h0);
        wb(2, 4'd7, 32'h3, 1'b0, 32'h0);
        tick; clear_wb;
        check("branch_blocks_head", 64'(count), 64'd4);
        push_exp(2'b01, 2'b00, 2'b00, 10'd0, 64'd0, {4'd0, 4'd4},
                 1'b1, 1'b1, 1'b1, 32'h40, 32'h100);
        wb(0, 4'd4, 32'h0, 1'b1, 32'h100);
        tick; clear_wb;
        tick;
        check("count_after_mispredict", 64'(count), 64'd0);
        tick; tick; tick;

        // Operand forwarding from the writeback ports.
        for (int i = 0; i < 4; i++) alloc(2'd0, 5'(10 + i), 32'(i * 4), 1'b0, i);
        rd_tag1 = 4'd3; rd_tag2 = 4'd2;
        wb(1, 4'd3, 32'h55, 1'b0, 32'h0);
        #1;
        check("fwd_ready1", 64'(rd_ready1), 64'd1);
        check("fwd_data1_port1", 64'(rd_data1), 64'h55);
        check("fwd_ready2_none", 64'(rd_ready2), 64'd0);
        check("fwd_data2_none", 64'(rd_data2), 64'd0);
        wb(2, 4'd3, 32'h66, 1'b0, 32'h0);
        #1;
        check("fwd_data1_port2", 64'(rd_data1), 64'h66);
        tick; clear_wb;
        check("stored_ready1", 64'(rd_ready1), 64'd1);
        check("stored_data1", 64'(rd_data1), 64'h66);
        flush = 1'b1; tick; flush = 1'b0;

        // Flush beats a same-cycle alloc and a pending commit.
        for (int i = 0; i < 14; i++) alloc(2'd0, 5'(i), 32'(i * 4), 1'b0, i);
        check("count_14", 64'(count), 64'd14);
        wb(0, 4'd0, 32'h1, 1'b0, 32'h0);
        tick; clear_wb;
        flush = 1'b1; alloc_valid = 1'b1; alloc_kind = 2'd0; alloc_rd = 5'd9;
        tick;
        flush = 1'b0;
        check("flush_count_0", 64'(count), 64'd0);
        check("flush_cm_valid", 64'(cm_valid), 64'd0);
        #1;
        check("alloc_tag_restart", 64'(alloc_tag), 64'd0);
        tick;
        alloc_valid = 1'b0;
        check("count_after_restart", 64'(count), 64'd1);
        tick; tick;

        check("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
